// File: rtl/ulbf_data_pkg.sv
// ulbf_data_pkg
// Shared definitions for the uplink beamformer AXI4-Stream to RAM capture
// stage: FSM state encoding, counter/address widths and the error counter
// saturation value.
package ulbf_data_pkg;

    localparam int ULBF_CNT_W  = 12;
    localparam int ULBF_ADDR_W = 16;

    localparam logic [15:0] ERR_CNT_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ulbf_state_e;

endpackage

// File: rtl/ulbf_data_wrap_cnt.sv
// ulbf_data_wrap_cnt
// Modulo counter: counts 0..max_val, returning to 0 on the increment that
// finds it at max_val.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   clear     - synchronous clear to 0 (wins over inc)
//   inc       - advance by one
//   max_val   - terminal count
//   count     - current value
//   wrap      - combinational pulse: inc while count == max_val
module ulbf_data_wrap_cnt #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         inc,
    input  logic [W-1:0] max_val,
    output logic [W-1:0] count,
    output logic         wrap
);

    logic [W-1:0] count_r;
    logic         at_max_s;

    assign at_max_s = (count_r == max_val);
    assign wrap     = inc & at_max_s;
    assign count    = count_r;

    // Counter register with clear priority and modulo wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (inc) begin
            if (at_max_s) begin
                count_r <= '0;
            end else begin
                count_r <= count_r + W'(1);
            end
        end
    end

endmodule

// File: rtl/ulbf_data_axis2ram_64b.sv
// ulbf_data_axis2ram_64b
// Capture stage for the uplink beamformer: accepts a 64-bit AXI4-Stream,
// writes each beat into a RAM write port (address wraps at a programmable
// depth), counts blocks/iterations, checks TLAST placement and raises done
// after niter blocks.
// Optional build macro ULBF_DATA_AXIS2RAM_CHECKSUM_EN adds a rotate-xor
// checksum output over accepted (keep-masked) data.
// Ports:
//   s_axis_clk/s_axis_rst - clock, synchronous active-high reset
//   go, done              - capture enable level / capture complete
//   block_size, niter, rollover_addr - configuration, latched at start
//   s_axis_*              - AXI4-Stream slave
//   ram_we/ram_addr/ram_din - registered RAM write port (1-cycle latency)
//   beat_count, tlast_err, err_count - status
module ulbf_data_axis2ram_64b
    import ulbf_data_pkg::*;
#(
    parameter int DATA_WIDTH     = 64,
    parameter int GO_SYNC_STAGES = 3
) (
    input  logic                      s_axis_clk,
    input  logic                      s_axis_rst,
    input  logic                      go,
    output logic                      done,
    input  logic [ULBF_CNT_W-1:0]     block_size,
    input  logic [ULBF_CNT_W-1:0]     niter,
    input  logic [ULBF_ADDR_W-1:0]    rollover_addr,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    input  logic                      s_axis_tlast,
    input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0]   s_axis_tkeep,
`ifdef ULBF_DATA_AXIS2RAM_CHECKSUM_EN
    output logic [DATA_WIDTH-1:0]     checksum,
`endif
    output logic [DATA_WIDTH/8-1:0]   ram_we,
    output logic [ULBF_ADDR_W-1:0]    ram_addr,
    output logic [DATA_WIDTH-1:0]     ram_din,
    output logic [31:0]               beat_count,
    output logic                      tlast_err,
    output logic [15:0]               err_count
);

    logic [GO_SYNC_STAGES-1:0] go_sync_r;
    logic                      go_int_s;
    ulbf_state_e               state_r, state_nxt_s;
    logic [ULBF_CNT_W-1:0]     bs_m1_r, ni_m1_r;
    logic [ULBF_ADDR_W-1:0]    ro_m1_r;
    logic                      free_run_r;
    logic                      tready_r, done_r, tlast_err_r;
    logic [DATA_WIDTH/8-1:0]   ram_we_r;
    logic [ULBF_ADDR_W-1:0]    ram_addr_r;
    logic [DATA_WIDTH-1:0]     ram_din_r;
    logic [31:0]               beat_count_r;
    logic [15:0]               err_count_r;
    logic [ULBF_CNT_W-1:0]     block_cnt_s, iter_cnt_s;
    logic [ULBF_ADDR_W-1:0]    wr_addr_s;
    logic                      block_wrap_s, iter_wrap_s, addr_wrap_unused_s;
    logic                      start_s, accept_s, final_s, tlast_bad_s;

    assign go_int_s    = go_sync_r[GO_SYNC_STAGES-1];
    assign start_s     = (state_r == IDLE) & go_int_s;
    // go_int low aborts: a beat presented on that edge is not taken.
    assign accept_s    = s_axis_tvalid & tready_r & go_int_s & (state_r == RUN);
    // iter counter wraps exactly on the last beat of block niter-1.
    assign final_s     = iter_wrap_s & ~free_run_r;
    assign tlast_bad_s = accept_s & (s_axis_tlast != (block_cnt_s == bs_m1_r));

    assign done          = done_r;
    assign s_axis_tready = tready_r;
    assign ram_we        = ram_we_r;
    assign ram_addr      = ram_addr_r;
    assign ram_din       = ram_din_r;
    assign beat_count    = beat_count_r;
    assign tlast_err     = tlast_err_r;
    assign err_count     = err_count_r;

    // go synchroniser shift chain; the top bit is go_int.
    always_ff @(posedge s_axis_clk) begin
        if (s_axis_rst) begin
            go_sync_r <= '0;
        end else begin
            go_sync_r <= (go_sync_r << 1) | GO_SYNC_STAGES'(go);
        end
    end

    // Next-state logic for the capture FSM.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (go_int_s) state_nxt_s = RUN;
                else          state_nxt_s = IDLE;
            end
            RUN: begin
                if (!go_int_s)    state_nxt_s = IDLE;
                else if (final_s) state_nxt_s = DONE;
                else              state_nxt_s = RUN;
            end
            DONE: begin
                if (!go_int_s) state_nxt_s = IDLE;
                else           state_nxt_s = DONE;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register plus ready/done, both derived from the next state so
    // tready drops on the very edge that enters DONE.
    always_ff @(posedge s_axis_clk) begin
        if (s_axis_rst) begin
            state_r  <= IDLE;
            tready_r <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            tready_r <= (state_nxt_s == RUN);
            done_r   <= (state_nxt_s == DONE);
        end
    end

    // Configuration latched at start; the -1 wrap maps 0 to the maximum.
    always_ff @(posedge s_axis_clk) begin
        if (s_axis_rst) begin
            bs_m1_r    <= '0;
            ni_m1_r    <= '0;
            ro_m1_r    <= '0;
            free_run_r <= 1'b0;
        end else if (start_s) begin
            bs_m1_r    <= block_size - 12'd1;
            ni_m1_r    <= niter - 12'd1;
            ro_m1_r    <= rollover_addr - 16'd1;
            free_run_r <= (niter == 12'd0);
        end
    end

    ulbf_data_wrap_cnt #(.W(ULBF_CNT_W)) u_block_cnt (
        .clk(s_axis_clk), .rst(s_axis_rst), .clear(start_s), .inc(accept_s),
        .max_val(bs_m1_r), .count(block_cnt_s), .wrap(block_wrap_s)
    );

    ulbf_data_wrap_cnt #(.W(ULBF_CNT_W)) u_iter_cnt (
        .clk(s_axis_clk), .rst(s_axis_rst), .clear(start_s), .inc(block_wrap_s),
        .max_val(ni_m1_r), .count(iter_cnt_s), .wrap(iter_wrap_s)
    );

    ulbf_data_wrap_cnt #(.W(ULBF_ADDR_W)) u_wr_addr (
        .clk(s_axis_clk), .rst(s_axis_rst), .clear(start_s), .inc(accept_s),
        .max_val(ro_m1_r), .count(wr_addr_s), .wrap(addr_wrap_unused_s)
    );

    // Registered RAM write port; we is zero on cycles without an accept.
    always_ff @(posedge s_axis_clk) begin
        if (s_axis_rst) begin
            ram_we_r   <= '0;
            ram_addr_r <= '0;
            ram_din_r  <= '0;
        end else begin
            ram_we_r <= accept_s ? s_axis_tkeep : '0;
            if (accept_s) begin
                ram_addr_r <= wr_addr_s;
                ram_din_r  <= s_axis_tdata;
            end
        end
    end

    // Beat counter and TLAST error status, cleared on each start.
    always_ff @(posedge s_axis_clk) begin
        if (s_axis_rst) begin
            beat_count_r <= '0;
            tlast_err_r  <= 1'b0;
            err_count_r  <= '0;
        end else if (start_s) begin
            beat_count_r <= '0;
            tlast_err_r  <= 1'b0;
            err_count_r  <= '0;
        end else begin
            if (accept_s) begin
                beat_count_r <= beat_count_r + 32'd1;
            end
            if (tlast_bad_s) begin
                tlast_err_r <= 1'b1;
                if (err_count_r != ERR_CNT_MAX) begin
                    err_count_r <= err_count_r + 16'd1;
                end
            end
        end
    end

`ifdef ULBF_DATA_AXIS2RAM_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] checksum_r;

    function automatic logic [DATA_WIDTH-1:0] keep_mask(
        input logic [DATA_WIDTH-1:0]   d,
        input logic [DATA_WIDTH/8-1:0] k
    );
        logic [DATA_WIDTH-1:0] m;
        m = '0;
        for (int b = 0; b < DATA_WIDTH/8; b++) begin
            m[b*8 +: 8] = k[b] ? d[b*8 +: 8] : 8'h00;
        end
        return m;
    endfunction

    assign checksum = checksum_r;

    // Rotate-left-by-one then xor in the keep-masked data of each accept.
    always_ff @(posedge s_axis_clk) begin
        if (s_axis_rst) begin
            checksum_r <= '0;
        end else if (start_s) begin
            checksum_r <= '0;
        end else if (accept_s) begin
            checksum_r <= {checksum_r[DATA_WIDTH-2:0], checksum_r[DATA_WIDTH-1]}
                          ^ keep_mask(s_axis_tdata, s_axis_tkeep);
        end
    end
`endif

endmodule

// File: tb/tb_ulbf_data_axis2ram_64b.sv
// tb_ulbf_data_axis2ram_64b
// Directed self-checking bench for ulbf_data_axis2ram_64b. A monitor logs
// every RAM write; each scenario then compares the log and status outputs
// against values computed here from the stimulus.
module tb_ulbf_data_axis2ram_64b;

    logic        clk;
    logic        rst;
    logic        go;
    logic        done;
    logic [11:0] block_size;
    logic [11:0] niter;
    logic [15:0] rollover_addr;
    logic        tvalid;
    logic        tready;
    logic        tlast;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic [7:0]  ram_we;
    logic [15:0] ram_addr;
    logic [63:0] ram_din;
    logic [31:0] beat_count;
    logic        tlast_err;
    logic [15:0] err_count;
`ifdef ULBF_DATA_AXIS2RAM_CHECKSUM_EN
    logic [63:0] checksum;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] wq_addr[$];
    logic [63:0] wq_data[$];
    logic [7:0]  wq_we[$];

    ulbf_data_axis2ram_64b dut (
        .s_axis_clk(clk), .s_axis_rst(rst), .go(go), .done(done),
        .block_size(block_size), .niter(niter), .rollover_addr(rollover_addr),
        .s_axis_tvalid(tvalid), .s_axis_tready(tready), .s_axis_tlast(tlast),
        .s_axis_tdata(tdata), .s_axis_tkeep(tkeep),
`ifdef ULBF_DATA_AXIS2RAM_CHECKSUM_EN
        .checksum(checksum),
`endif
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .beat_count(beat_count), .tlast_err(tlast_err), .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Log every RAM write seen half a cycle after the registering edge.
    always @(negedge clk) begin
        if (!rst && ram_we != 8'h00) begin
            wq_addr.push_back(ram_addr);
            wq_data.push_back(ram_din);
            wq_we.push_back(ram_we);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pat(input int t, input int i);
        return {8'(t), 24'h5AC3A5, 32'(i)};
    endfunction

    task automatic clear_log();
        wq_addr.delete();
        wq_data.delete();
        wq_we.delete();
    endtask

    task automatic wait_ready(input string tag);
        int cyc = 0;
        while (tready !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check_value(tag, tready, 1);
    endtask

    task automatic wait_idle(input string tag);
        int cyc = 0;
        go     = 1'b0;
        tvalid = 1'b0;
        while ((done !== 1'b0 || tready !== 1'b0) && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check_value(tag, {done, tready}, 0);
    endtask

    // Present beats until n are accepted; returns at the negedge before the
    // edge that takes the final beat, with that beat still driven.
    task automatic send_beats(input int t, input int n, input int bs, input bit bad,
                              input bit rnd, input logic [7:0] keep);
        int  i = 0;
        int  cyc = 0;
        bit  last;
        while (i < n && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            tvalid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tdata  = pat(t, i);
            tkeep  = keep;
            last   = ((i % bs) == bs - 1);
            if (bad && i == 2) last = 1'b1;
            if (bad && i == 3) last = 1'b0;
            tlast  = last;
            if (tvalid && tready) i++;
        end
        check_value($sformatf("t%0d_sent", t), 64'(i), 64'(n));
    endtask

    task automatic verify_log(input int t, input int n, input int ro, input logic [7:0] keep);
        check_value($sformatf("t%0d_nwrites", t), 64'(wq_addr.size()), 64'(n));
        for (int i = 0; i < n && i < wq_addr.size(); i++) begin
            check_value($sformatf("t%0d_addr%0d", t, i), 64'(wq_addr[i]), 64'(i % ro));
            check_value($sformatf("t%0d_data%0d", t, i), wq_data[i], pat(t, i));
            check_value($sformatf("t%0d_we%0d", t, i), 64'(wq_we[i]), 64'(keep));
        end
    endtask

    // Run one complete capture and check the final status.
    task automatic run_capture(input int t, input int bs, input int ni, input int ro,
                               input bit bad, input bit rnd, input logic [7:0] keep,
                               input int exp_errs);
        block_size    = 12'(bs);
        niter         = 12'(ni);
        rollover_addr = 16'(ro);
        go            = 1'b1;
        clear_log();
        wait_ready($sformatf("t%0d_ready", t));
        send_beats(t, bs * ni, bs, bad, rnd, keep);
        check_value($sformatf("t%0d_done_pre", t), done, 0);
        @(negedge clk);
        check_value($sformatf("t%0d_done", t), done, 1);
        check_value($sformatf("t%0d_tready_off", t), tready, 0);
        check_value($sformatf("t%0d_beats", t), beat_count, 64'(bs * ni));
        check_value($sformatf("t%0d_tlast_err", t), tlast_err, (exp_errs != 0) ? 64'd1 : 64'd0);
        check_value($sformatf("t%0d_err_count", t), err_count, 64'(exp_errs));
        // Keep offering data after done; none of it may be taken.
        tvalid = 1'b1;
        repeat (6) @(negedge clk);
        check_value($sformatf("t%0d_done_hold", t), done, 1);
        check_value($sformatf("t%0d_beats_hold", t), beat_count, 64'(bs * ni));
        verify_log(t, bs * ni, ro, keep);
        wait_idle($sformatf("t%0d_idle", t));
    endtask

    initial begin
        rst = 1'b1; go = 1'b0; tvalid = 1'b0; tlast = 1'b0;
        tdata = 64'h0; tkeep = 8'h00;
        block_size = 12'd0; niter = 12'd0; rollover_addr = 16'd0;
        repeat (3) @(negedge clk);
        check_value("rst_done", done, 0);
        check_value("rst_tready", tready, 0);
        check_value("rst_we", ram_we, 0);
        check_value("rst_addr", ram_addr, 0);
        check_value("rst_din", ram_din, 0);
        check_value("rst_beats", beat_count, 0);
        check_value("rst_err", {tlast_err, err_count}, 0);
        rst = 1'b0;
        @(negedge clk);

        run_capture(1, 8, 4, 64, 1'b0, 1'b0, 8'hFF, 0);
        run_capture(2, 4, 3, 5, 1'b0, 1'b0, 8'h3C, 0);
        run_capture(3, 4, 2, 64, 1'b1, 1'b0, 8'hFF, 2);
        run_capture(4, 16, 2, 64, 1'b0, 1'b1, 8'hFF, 0);

        // Abort after 5 beats, then restart with a short capture.
        block_size = 12'd8; niter = 12'd4; rollover_addr = 16'd64;
        go = 1'b1;
        clear_log();
        wait_ready("t5_ready");
        send_beats(5, 5, 8, 1'b0, 1'b0, 8'hFF);
        @(negedge clk);
        tvalid = 1'b0;
        go = 1'b0;
        wait_idle("t5_abort_idle");
        check_value("t5_abort_beats", beat_count, 5);
        check_value("t5_abort_writes", 64'(wq_addr.size()), 5);
        block_size = 12'd3; niter = 12'd1;
        go = 1'b1;
        clear_log();
        wait_ready("t5_restart_ready");
        check_value("t5_restart_beats0", beat_count, 0);
        send_beats(5, 3, 3, 1'b0, 1'b0, 8'hFF);
        @(negedge clk);
        check_value("t5_restart_done", done, 1);
        tvalid = 1'b0;
        repeat (2) @(negedge clk);
        verify_log(5, 3, 64, 8'hFF);
        wait_idle("t5_idle");

        // Reset pulse in the middle of a block.
        block_size = 12'd8; niter = 12'd4; rollover_addr = 16'd64;
        go = 1'b1;
        clear_log();
        wait_ready("t6_ready");
        send_beats(6, 3, 8, 1'b0, 1'b0, 8'hFF);
        @(negedge clk);
        check_value("t6_pending_we", ram_we, 8'hFF);
        check_value("t6_pending_addr", ram_addr, 2);
        rst = 1'b1;
        @(negedge clk);
        check_value("t6_rst_we", ram_we, 0);
        check_value("t6_rst_addr", ram_addr, 0);
        check_value("t6_rst_din", ram_din, 0);
        check_value("t6_rst_flags", {done, tready, tlast_err}, 0);
        check_value("t6_rst_beats", beat_count, 0);
        check_value("t6_rst_errs", err_count, 0);
        rst = 1'b0;
        tvalid = 1'b0;
        clear_log();
        wait_ready("t6_restart_ready");
        send_beats(6, 4, 8, 1'b0, 1'b0, 8'hFF);
        @(negedge clk);
        tvalid = 1'b0;
        check_value("t6_restart_beats", beat_count, 4);
        repeat (2) @(negedge clk);
        verify_log(6, 4, 64, 8'hFF);
        wait_idle("t6_idle");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
